// File: rtl/lin_add_pkg.sv
// Shared constants, FSM state type and linear-stage group helpers for lin_add_seq.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: NBIT/NNL/W/NBEAT sizing, state_t, grp_start/grp_len/grp_mask.
package lin_add_pkg;

    localparam int NBIT  = 7;                          // adder width
    localparam int NNL   = 2**(NBIT+1) - NBIT - 2;     // non-linear term vector width (247)
    localparam int W     = 32;                         // stream word width
    localparam int NBEAT = (NNL + W - 1) / W;          // beats per operation (8)
    localparam int BCW   = $clog2(NBEAT);              // beat counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Group length for sum bit i (i >= 1): inter_1 = 3, inter_{i+1} = inter_i + 2**(i+1).
    function automatic int grp_len(input int i);
        int inter;
        inter = 3;
        for (int k = 1; k < i; k++) begin
            inter = inter + 2**(k+1);
        end
        return inter;
    endfunction

    // First term index of group i.
    function automatic int grp_start(input int i);
        return grp_len(i) - i - 2;
    endfunction

    // One-hot-run mask selecting the terms of group i out of n.
    function automatic logic [NNL-1:0] grp_mask(input int i);
        logic [NNL-1:0] ones;
        ones = '1;
        return (ones >> (NNL - grp_len(i))) << grp_start(i);
    endfunction

endpackage

// File: rtl/gen_linear_part.sv
// Linear sum stage of the carry-split adder: s[i] = a[i]^b[i]^(XOR of n group i), s[0] uses c_in.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports: i_a/i_b operands, i_c_in carry in, i_n non-linear term vector, o_s sum.
module gen_linear_part
    import lin_add_pkg::*;
(
    input  logic [NBIT-1:0] i_a,
    input  logic [NBIT-1:0] i_b,
    input  logic            i_c_in,
    input  logic [NNL-1:0]  i_n,
    output logic [NBIT-1:0] o_s
);

    assign o_s[0] = i_a[0] ^ i_b[0] ^ i_c_in;

    // The top term n[NNL-1] falls outside every group mask and never reaches s.
    for (genvar gi = 1; gi < NBIT; gi++) begin : g_bit
        assign o_s[gi] = i_a[gi] ^ i_b[gi] ^ (^(i_n & grp_mask(gi)));
    end

endmodule

// File: rtl/lin_add_seq.sv
// Sequencer: takes one operand set, gathers the NNL-bit term vector over NBEAT W-bit beats, registers the linear sum.
// Latency: res_valid rises NBEAT+1 clocks after the operand handshake when beats arrive back to back.
// Backpressure: nl_valid gaps stall LOAD; res_ready low holds DONE; op_ready only in IDLE.
//
// Ports: clk/rst (async active-high), clr (sync abort), op_* operand handshake with a/b/c_in,
//        nl_* term stream, res_* result handshake with s/res_err, busy = not IDLE.
module lin_add_seq
    import lin_add_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c_in,
    input  logic            nl_valid,
    output logic            nl_ready,
    input  logic [W-1:0]    nl_data,
    input  logic            nl_last,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [NBIT-1:0] s,
    output logic            res_err,
    output logic            busy
);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [NBIT-1:0] r_a;
    logic [NBIT-1:0] r_b;
    logic            r_c_in;
    logic [NNL-1:0]  r_n;
    logic [BCW-1:0]  r_beat;
    logic            r_err;
    logic [NBIT-1:0] r_s;
    logic            r_res_err;

    logic [NBIT-1:0] w_s;
    logic [NNL-1:0]  w_beat_dat;
    logic [NNL-1:0]  w_beat_msk;
    logic [NNL-1:0]  w_n_next;
    logic            w_op_fire;
    logic            w_nl_fire;
    logic            w_last_slot;
    logic            w_load_exit;
    logic            w_err_nxt;

    // clr wins over any handshake in the same cycle.
    assign w_op_fire   = op_valid & op_ready & ~clr;
    assign w_nl_fire   = nl_valid & nl_ready & ~clr;
    assign w_last_slot = (r_beat == BCW'(NBEAT - 1));
    assign w_load_exit = w_nl_fire & (nl_last | w_last_slot);
    // Clean framing only when last coincides with the final slot.
    assign w_err_nxt   = ~(nl_last & w_last_slot);

    // Place the beat at its slot; shifting in NNL width drops bits past the top term.
    assign w_beat_dat = {{(NNL-W){1'b0}}, nl_data} << (32'(r_beat) * W);
    assign w_beat_msk = {{(NNL-W){1'b0}}, {W{1'b1}}} << (32'(r_beat) * W);
    assign w_n_next   = (r_n & ~w_beat_msk) | (w_beat_dat & w_beat_msk);

    // FSM next-state and decoded handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        op_ready    = 1'b0;
        nl_ready    = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
                if (op_valid) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                nl_ready = 1'b1;
                if (nl_valid && (nl_last || w_last_slot)) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, term collection and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_c_in    <= 1'b0;
            r_n       <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_s       <= '0;
            r_res_err <= 1'b0;
        end else if (clr) begin
            r_beat <= '0;
        end else if (w_op_fire) begin
            r_a    <= a;
            r_b    <= b;
            r_c_in <= c_in;
            r_n    <= '0;
            r_beat <= '0;
            r_err  <= 1'b0;
        end else if (w_nl_fire) begin
            r_n    <= w_n_next;
            r_beat <= r_beat + BCW'(1);
            if (w_load_exit) begin
                r_err <= w_err_nxt;
            end
        end else if (r_state == ST_CALC) begin
            r_s       <= w_s;
            r_res_err <= r_err;
        end
    end

    gen_linear_part u_linear (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_c_in (r_c_in),
        .i_n    (r_n),
        .o_s    (w_s)
    );

    assign s       = r_s;
    assign res_err = r_res_err;

endmodule

// File: doc/lin_add_seq.md
Name: lin_add_seq

Overview:
- Sequencer that feeds the linear sum stage of the carry-split adder.
- Accepts one operand set (a, b, c_in) per operation, then collects the wide non-linear term vector n over a narrow W-bit stream.
- Evaluates the linear stage once and holds a registered sum until the consumer accepts it.
- Sits between the non-linear term generator (stream source) and the result consumer.

Parameters:
- NBIT, 7, adder width in bits
- NNL, 2**(NBIT+1)-NBIT-2 (247), width of the non-linear term vector
- W, 32, non-linear stream word width
- NBEAT, (NNL+W-1)/W (8), beats per operation

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- clr  in  1  synchronous abort; returns the FSM to IDLE
- op_valid  in  1  operand set valid
- op_ready  out  1  operand set accepted when op_valid is also high
- a  in  NBIT  operand A
- b  in  NBIT  operand B
- c_in  in  1  carry in
- nl_valid  in  1  non-linear stream word valid
- nl_ready  out  1  non-linear stream ready
- nl_data  in  W  non-linear word; beat k carries n[k*W +: W]
- nl_last  in  1  marks the final beat
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- s  out  NBIT  sum
- res_err  out  1  stream framing error for this result
- busy  out  1  FSM is not in IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; s=0, res_valid=0, res_err=0, nl_ready=0, busy=0; op_ready=1 (decoded from IDLE).
  - a/b/c_in/n registers=0; beat_cnt=0.
- States: IDLE, LOAD, CALC, DONE. op_ready=1 only in IDLE; nl_ready=1 only in LOAD; res_valid=1 only in DONE.
- IDLE:
  - On op_valid&op_ready: capture a, b, c_in; clear the n register to 0; beat_cnt=0; clear the error flag; go to LOAD.
- LOAD, on each nl_valid&nl_ready:
  - Write nl_data into n[beat_cnt*W +: W]. Bits at index >= NNL are discarded.
  - beat_cnt increments.
- LOAD exit conditions:
  - nl_last on beat NBEAT-1: go to CALC, err=0.
  - nl_last on beat < NBEAT-1 (early): go to CALC, err=1. Unwritten slots stay 0.
  - Beat NBEAT-1 without nl_last: go to CALC, err=1. No further beats are accepted.
- CALC (one cycle): register s from the linear stage and res_err=err; go to DONE.
- Linear stage:
  - s[0]=a[0]^b[0]^c_in.
  - For i>=1: s[i]=a[i]^b[i]^XOR of n group i. Group i starts at inter_i-i-2 with length inter_i, where inter_1=3 and inter_{i+1}=inter_i+2**(i+1).
  - For NBIT=7 the groups are n[0..2], [3..9], [10..24], [25..55], [56..118], [119..245]. n[246] is unused.
- DONE: hold s and res_err stable until res_ready, then go to IDLE. No new op is accepted in the same cycle.
- Latency: with back-to-back beats, res_valid rises NBEAT+1 clocks after the op handshake edge.
- Stall handling: nl_valid gaps stall LOAD indefinitely; res_ready low holds DONE.
- clr: from any state, next state=IDLE; res_valid=0; beat_cnt=0. clr has priority over handshakes in the same cycle.
- rst mid-operation: immediate return to reset values; the partial n is discarded.
- busy = (state != IDLE).

Decomposition:
- Package lin_add_pkg: NBIT, NNL, W, NBEAT, the state enum, and a function giving group start/length per bit.
- One sub-module: the existing combinational gen_linear_part, instanced once and fed from the captured a/b/c_in/n registers.
- The FSM, beat counter and n register stay in lin_add_seq.

Test Plan:
- Sum, no terms: a=7'h55, b=7'h0F, c_in=1, all beats 0, last on beat 7 -> s=7'h5B, res_err=0, res_valid 9 clocks after the op handshake.
- Term n[0]: a=0, b=0, c_in=0, beat0=32'h1, other beats 0 -> s=7'h02. With beat0=32'h8 (n[3]) -> s=7'h04.
- Top group: beat7 bit 13 set (n[237]), rest 0, a=b=0 -> s=7'h40. beat7 bit 22 set (n[246], unused) -> s=7'h00.
- Framing: nl_last on beat 3 -> res_err=1, no further nl_ready. 8 beats with no nl_last -> res_err=1, nl_ready drops after beat 7.
- Backpressure/stall: nl_valid toggled every other cycle and res_ready held low 5 cycles -> s stable throughout; op_ready=0 until res_ready.
- Abort: clr pulsed during beat 4 -> IDLE next cycle. rst asserted in DONE -> s=0, res_valid=0 immediately, op_ready=1. A following op completes correctly.
